memory_responder: RTL and testbench

Memory-side responder to the CPU control unit's mem_read/mem_write strobes. Holds a word-addressed RAM; takes its address from MAR and its write data from MDR. Returns read data to the MDR input path with a one-cycle mem_ready pulse after a fixed latency, so the control FSM can wait on completion instead of assuming timing.

---
 rtl/memory_responder_if.sv | 26 ++
 rtl/memory_responder.sv | 163 ++++++++++++++++
 tb/tb_memory_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - control-unit to memory-responder strobe/response bundle
interface memory_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  mem_ready;
  logic                  mem_error;
  logic                  busy;

  // Control unit side: issues strobes, address (MAR) and write data (MDR).
  modport master (
    output mem_read, mem_write, address, data_in,
    input  data_out, mem_ready, mem_error, busy
  );

  // Memory side: samples strobes and returns completion/response.
  modport slave (
    input  mem_read, mem_write, address, data_in,
    output data_out, mem_ready, mem_error, busy
  );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-addressed RAM answering mem_read/mem_write with a timed mem_ready pulse
module memory_responder #(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  memory_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // The counter is preloaded with LATENCY-1 so that the access lands exactly
  // LATENCY edges after the request sample; latencies are limited to 1..15.
  localparam logic [3:0] READ_LOAD  = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WRITE_LOAD = 4'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_WAIT  = 3'd1,
    WRITE_WAIT = 3'd2,
    RESP       = 3'd3,
    REARM      = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [3:0]            count;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  error_pulse;

  // Storage is deliberately left out of reset so its contents survive it.
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  req_read;
  logic                  req_write;
  logic                  req_both;
  logic                  count_done;
  logic                  ram_we;
  logic                  ram_re;

  assign req_read   = bus.mem_read  & ~bus.mem_write;
  assign req_write  = bus.mem_write & ~bus.mem_read;
  assign req_both   = bus.mem_read  &  bus.mem_write;
  assign count_done = (count == 4'd0);

  // Accesses happen only on the final wait edge, using the latched request,
  // so anything the control unit does to MAR/MDR afterwards is irrelevant.
  // An async reset forces IDLE before that edge, which cancels the access.
  assign ram_we = (state == WRITE_WAIT) && count_done;
  assign ram_re = (state == READ_WAIT)  && count_done;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; strobes are only looked at in IDLE and REARM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_read) begin
          state_next = READ_WAIT;
        end else if (req_write) begin
          state_next = WRITE_WAIT;
        end else if (req_both) begin
          state_next = REARM;
        end
      end
      READ_WAIT: begin
        if (count_done) begin
          state_next = RESP;
        end
      end
      WRITE_WAIT: begin
        if (count_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = REARM;
      end
      REARM: begin
        // A strobe still held from the finished request must drop first.
        if (!bus.mem_read && !bus.mem_write) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, latency counter, read-data register and error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= 4'd0;
      lat_addr    <= '0;
      lat_data    <= '0;
      read_data   <= '0;
      error_pulse <= 1'b0;
    end else begin
      // High for exactly the cycle after a conflicting sample; the FSM is in
      // REARM by then so it cannot re-fire on the next edge.
      error_pulse <= (state == IDLE) && req_both;

      case (state)
        IDLE: begin
          if (req_read) begin
            count    <= READ_LOAD;
            lat_addr <= bus.address;
            lat_data <= bus.data_in;
          end else if (req_write) begin
            count    <= WRITE_LOAD;
            lat_addr <= bus.address;
            lat_data <= bus.data_in;
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          if (!count_done) begin
            count <= count - 4'd1;
          end
        end
        default: begin
          count <= count;
        end
      endcase

      // data_out only ever changes on a completed read.
      if (ram_re) begin
        read_data <= ram[lat_addr];
      end
    end
  end

  // RAM write port; commits on the same edge that raises mem_ready.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[lat_addr] <= lat_data;
    end
  end

  // Outputs: mem_ready is the RESP state itself, so it is a single cycle and
  // can never coincide with mem_error (which only follows an IDLE sample).
  always_comb begin
    bus.mem_ready = (state == RESP);
    bus.busy      = (state != IDLE);
    bus.mem_error = error_pulse;
    bus.data_out  = read_data;
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed self-checking bench for memory_responder
module tb_memory_responder;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  memory_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) a ();
  memory_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b ();

  // Instance a: default latencies (read 2, write 1).
  memory_responder #(
    .ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(2), .WRITE_LATENCY(1)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (a)
  );

  // Instance b: slow writes (latency 3) for the reset-before-commit case.
  memory_responder #(
    .ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(2), .WRITE_LATENCY(3)
  ) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [8:0] adr, input logic [31:0] d);
    if (sel) begin
      b.mem_read = rd; b.mem_write = wr; b.address = adr; b.data_in = d;
    end else begin
      a.mem_read = rd; a.mem_write = wr; a.address = adr; a.data_in = d;
    end
  endtask

  task automatic observe(input bit sel, output logic rdy, output logic err,
                         output logic bsy, output logic [31:0] dout);
    if (sel) begin
      rdy = b.mem_ready; err = b.mem_error; bsy = b.busy; dout = b.data_out;
    end else begin
      rdy = a.mem_ready; err = a.mem_error; bsy = a.busy; dout = a.data_out;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, hold strobes for 'hold' sampling edges (then drop them
  // and zero address/data), and record at which edge (0 = sample edge) each
  // response appears and when busy first falls.
  task automatic run_op(input string tag, input bit sel, input logic rd, input logic wr,
                        input logic [8:0] adr, input logic [31:0] d, input int hold,
                        input int exp_ready_at, input int exp_err_at, input int exp_idle,
                        input bit chk_data, input logic [31:0] exp_data);
    int          n_ready;
    int          ready_at;
    int          n_err;
    int          err_at;
    int          idle_at;
    int          both;
    logic        rdy;
    logic        err;
    logic        bsy;
    logic [31:0] dout;
    logic [31:0] dout_at_ready;
    n_ready = 0; ready_at = -1; n_err = 0; err_at = -1; idle_at = -1; both = 0;
    dout_at_ready = 32'h0;
    drive(sel, rd, wr, adr, d);
    for (int e = 0; e < 40 && idle_at < 0; e++) begin
      tick();
      observe(sel, rdy, err, bsy, dout);
      if (rdy) begin n_ready++; ready_at = e; dout_at_ready = dout; end
      if (err) begin n_err++; err_at = e; end
      if (rdy && err) both++;
      if (!bsy) idle_at = e;
      if (e == hold - 1) drive(sel, 1'b0, 1'b0, 9'h000, 32'h0);
    end
    drive(sel, 1'b0, 1'b0, 9'h000, 32'h0);
    check({tag, ".ready_count"}, 32'(n_ready), (exp_ready_at >= 0) ? 32'd1 : 32'd0);
    check({tag, ".ready_edge"},  32'(ready_at), 32'(exp_ready_at));
    check({tag, ".error_count"}, 32'(n_err), (exp_err_at >= 0) ? 32'd1 : 32'd0);
    check({tag, ".error_edge"},  32'(err_at), 32'(exp_err_at));
    check({tag, ".idle_edge"},   32'(idle_at), 32'(exp_idle));
    check({tag, ".ready_and_error"}, 32'(both), 32'd0);
    if (chk_data) check({tag, ".data_out"}, dout_at_ready, exp_data);
  endtask

  int n_late;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
    tick();
    check("reset.data_out",  a.data_out,  32'h0);
    check("reset.mem_ready", 32'(a.mem_ready), 32'd0);
    check("reset.mem_error", 32'(a.mem_error), 32'd0);
    check("reset.busy",      32'(a.busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Write then read back; write strobe held over 3 edges.
    run_op("wr_005", 1'b0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 3, 1, -1, 3, 1'b0, 32'h0);
    run_op("rd_005", 1'b0, 1'b1, 1'b0, 9'h005, 32'h0, 1, 2, -1, 4, 1'b1, 32'hDEADBEEF);

    // Held read strobe: one response, busy until the strobe drops.
    run_op("wr_010",   1'b0, 1'b0, 1'b1, 9'h010, 32'h0BADF00D, 1, 1, -1, 3, 1'b0, 32'h0);
    run_op("held_rd",  1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 10, 2, -1, 10, 1'b1, 32'h0BADF00D);

    // Conflicting strobes: error only, no access, location untouched.
    run_op("wr_020",   1'b0, 1'b0, 1'b1, 9'h020, 32'h12345678, 1, 1, -1, 3, 1'b0, 32'h0);
    run_op("illegal",  1'b0, 1'b1, 1'b1, 9'h020, 32'hFFFFFFFF, 1, -1, 0, 1, 1'b0, 32'h0);
    check("illegal.data_out_kept", a.data_out, 32'h0BADF00D);
    run_op("rd_020",   1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 1, 2, -1, 4, 1'b1, 32'h12345678);

    // Early strobe drop with the address moved to 0x000 afterwards.
    run_op("wr_000",   1'b0, 1'b0, 1'b1, 9'h000, 32'h11111111, 1, 1, -1, 3, 1'b0, 32'h0);
    run_op("wr_1ff",   1'b0, 1'b0, 1'b1, 9'h1FF, 32'hCAFEF00D, 1, 1, -1, 3, 1'b0, 32'h0);
    check("write.data_out_kept", a.data_out, 32'h12345678);
    run_op("early_drop", 1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, 2, -1, 4, 1'b1, 32'hCAFEF00D);

    // Reset one cycle into a read wait: immediate clear, no late pulse.
    drive(1'b0, 1'b1, 1'b0, 9'h005, 32'h0);
    tick();
    check("rst_rd.busy_before", 32'(a.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_rd.data_out",  a.data_out, 32'h0);
    check("rst_rd.mem_ready", 32'(a.mem_ready), 32'd0);
    check("rst_rd.busy",      32'(a.busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    n_late = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a.mem_ready) n_late++;
    end
    check("rst_rd.no_late_ready", 32'(n_late), 32'd0);
    check("rst_rd.data_out_after", a.data_out, 32'h0);
    run_op("persist_1ff", 1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, 2, -1, 4, 1'b1, 32'hCAFEF00D);

    // Slow write aborted by reset before its commit edge.
    run_op("b_wr_old", 1'b1, 1'b0, 1'b1, 9'h003, 32'h01020304, 1, 3, -1, 5, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 9'h003, 32'hAAAA5555);
    tick();
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
    tick();
    check("b_abort.ready_before", 32'(b.mem_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("b_abort.busy", 32'(b.busy), 32'd0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_op("b_rd_old", 1'b1, 1'b1, 1'b0, 9'h003, 32'h0, 1, 2, -1, 4, 1'b1, 32'h01020304);
    run_op("persist_010", 1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1, 2, -1, 4, 1'b1, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
